// File: rtl/ddr_cmd_dispatch.sv
// ddr_cmd_dispatch: arbitrates between a write FIFO pair (address + data)
// and a read-address FIFO, and issues one command at a time to a DDR
// memory-controller application port. Writes are preferred, but a waiting
// read is guaranteed service after STARVE_LIMIT consecutive write grants.
module ddr_cmd_dispatch #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         has_wr_adx,
    input  logic         has_wr_data,
    input  logic [26:0]  wr_adx_in,
    input  logic [127:0] wr_data_in,
    output logic         get_wr_adx,
    output logic         get_wr_data,
    input  logic         has_rd_adx,
    input  logic [26:0]  rd_adx_in,
    output logic         get_rd_adx,
    output logic         app_en,
    output logic [2:0]   app_cmd,
    output logic [26:0]  app_addr,
    input  logic         app_rdy,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    output logic [127:0] app_wdf_data,
    input  logic         app_wdf_rdy,
    output logic         busy,
    output logic [15:0]  wr_issued,
    output logic [15:0]  rd_issued
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_WR_CMD  = 2'd2,
        ST_RD_CMD  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           app_en_q, app_en_d;
    logic [2:0]     app_cmd_q, app_cmd_d;
    logic [26:0]    app_addr_q, app_addr_d;
    logic           app_wdf_wren_q, app_wdf_wren_d;
    logic           app_wdf_end_q, app_wdf_end_d;
    logic [127:0]   app_wdf_data_q, app_wdf_data_d;
    logic           busy_q, busy_d;
    logic [SW-1:0]  starve_cnt_q, starve_cnt_d;
    logic [15:0]    wr_issued_q, wr_issued_d;
    logic [15:0]    rd_issued_q, rd_issued_d;

    logic wr_elig_s;
    logic rd_elig_s;
    logic starve_at_limit_s;
    logic rd_wins_s;
    logic idle_s;
    logic grant_wr_s;
    logic grant_rd_s;

    // A write needs both its address and its data present; the pops are
    // gated by reset so no FIFO word is lost while reset is asserted.
    assign wr_elig_s         = has_wr_adx & has_wr_data;
    assign rd_elig_s         = has_rd_adx;
    assign starve_at_limit_s = (starve_cnt_q == SW'(STARVE_LIMIT));
    assign rd_wins_s         = rd_elig_s & (~wr_elig_s | starve_at_limit_s);
    assign idle_s            = (state_q == ST_IDLE) & ~reset;
    assign grant_wr_s        = idle_s & wr_elig_s & ~rd_wins_s;
    assign grant_rd_s        = idle_s & rd_wins_s;

    assign get_wr_adx   = grant_wr_s;
    assign get_wr_data  = grant_wr_s;
    assign get_rd_adx   = grant_rd_s;

    assign app_en       = app_en_q;
    assign app_cmd      = app_cmd_q;
    assign app_addr     = app_addr_q;
    assign app_wdf_wren = app_wdf_wren_q;
    assign app_wdf_end  = app_wdf_end_q;
    assign app_wdf_data = app_wdf_data_q;
    assign busy         = busy_q;
    assign wr_issued    = wr_issued_q;
    assign rd_issued    = rd_issued_q;

    // Next-state and next-output computation for the dispatch FSM.
    always_comb begin
        state_d        = state_q;
        app_en_d       = app_en_q;
        app_cmd_d      = app_cmd_q;
        app_addr_d     = app_addr_q;
        app_wdf_wren_d = app_wdf_wren_q;
        app_wdf_end_d  = app_wdf_end_q;
        app_wdf_data_d = app_wdf_data_q;
        starve_cnt_d   = starve_cnt_q;
        wr_issued_d    = wr_issued_q;
        rd_issued_d    = rd_issued_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_rd_s) begin
                    app_addr_d   = rd_adx_in;
                    app_cmd_d    = 3'b001;
                    app_en_d     = 1'b1;
                    starve_cnt_d = SW'(0);
                    state_d      = ST_RD_CMD;
                end else if (grant_wr_s) begin
                    app_addr_d     = wr_adx_in;
                    app_wdf_data_d = wr_data_in;
                    app_wdf_wren_d = 1'b1;
                    app_wdf_end_d  = 1'b1;
                    state_d        = ST_WR_DATA;
                    // Only writes that bypass a waiting read count toward starvation.
                    if (rd_elig_s && !starve_at_limit_s) begin
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end else begin
                        starve_cnt_d = starve_cnt_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (app_wdf_rdy) begin
                    app_wdf_wren_d = 1'b0;
                    app_wdf_end_d  = 1'b0;
                    app_en_d       = 1'b1;
                    app_cmd_d      = 3'b000;
                    state_d        = ST_WR_CMD;
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_CMD: begin
                if (app_rdy) begin
                    app_en_d    = 1'b0;
                    wr_issued_d = wr_issued_q + 16'd1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_WR_CMD;
                end
            end
            ST_RD_CMD: begin
                if (app_rdy) begin
                    app_en_d    = 1'b0;
                    rd_issued_d = rd_issued_q + 16'd1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RD_CMD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output flops; reset abandons any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            app_en_q       <= 1'b0;
            app_cmd_q      <= 3'b000;
            app_addr_q     <= 27'd0;
            app_wdf_wren_q <= 1'b0;
            app_wdf_end_q  <= 1'b0;
            app_wdf_data_q <= 128'd0;
            busy_q         <= 1'b0;
            starve_cnt_q   <= SW'(0);
            wr_issued_q    <= 16'd0;
            rd_issued_q    <= 16'd0;
        end else begin
            state_q        <= state_d;
            app_en_q       <= app_en_d;
            app_cmd_q      <= app_cmd_d;
            app_addr_q     <= app_addr_d;
            app_wdf_wren_q <= app_wdf_wren_d;
            app_wdf_end_q  <= app_wdf_end_d;
            app_wdf_data_q <= app_wdf_data_d;
            busy_q         <= busy_d;
            starve_cnt_q   <= starve_cnt_d;
            wr_issued_q    <= wr_issued_d;
            rd_issued_q    <= rd_issued_d;
        end
    end

endmodule

// File: doc/ddr_cmd_dispatch.md
DDR_CMD_DISPATCH -- requirements
Module: ddr_cmd_dispatch

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: maximum number of consecutive write grants while a read is waiting.
REQ-002 clk  in  1  single clock; all state on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 has_wr_adx, has_wr_data  in  1,1  write FIFO (first-word-fall-through) address and data non-empty.
REQ-005 wr_adx_in, wr_data_in  in  27,128  write FIFO head address and head data.
REQ-006 get_wr_adx, get_wr_data  out  1,1  write FIFO pop strobes, one cycle each.
REQ-007 has_rd_adx  in  1  read-address FIFO non-empty.
REQ-008 rd_adx_in  in  27  read-address FIFO head.
REQ-009 get_rd_adx  out  1  read-address FIFO pop strobe.
REQ-010 app_en, app_cmd, app_addr, app_rdy  out,out,out,in  1,3,27,1  memory-controller command port.
REQ-011 app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_rdy  out,out,out,in  1,1,128,1  memory-controller write-data port.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.
REQ-013 wr_issued, rd_issued  out  16,16  wrapping counts of accepted write and read commands.

Function
REQ-014 States: IDLE, WR_DATA, WR_CMD, RD_CMD; all app_* outputs, busy and the counters are registered.
REQ-015 In IDLE, the block shall consider a write eligible only when has_wr_adx and has_wr_data are both high, and a read eligible when has_rd_adx is high.
REQ-016 Arbitration: writes win over reads unless a read is eligible and starve_cnt equals STARVE_LIMIT, in which case the read wins.
REQ-017 starve_cnt: increments on each write grant made while a read is eligible; clears on a read grant; saturates at STARVE_LIMIT.
REQ-018 Write grant cycle:
  - get_wr_adx and get_wr_data pulse high (combinational, 1 cycle).
  - Capture wr_adx_in into app_addr and wr_data_in into app_wdf_data.
  - Next state WR_DATA with app_wdf_wren=1 and app_wdf_end=1.
REQ-019 WR_DATA: hold wren, end and data until app_wdf_rdy is sampled high; then deassert wren and end, set app_en=1 with app_cmd=3'b000, and go to WR_CMD.
REQ-020 WR_CMD: hold app_en, app_cmd and app_addr until app_rdy is sampled high; then deassert app_en, increment wr_issued, and go to IDLE.
REQ-021 Read grant cycle:
  - get_rd_adx pulses high.
  - Capture rd_adx_in into app_addr.
  - Set app_en=1 with app_cmd=3'b001 and go to RD_CMD.
REQ-022 RD_CMD: hold the command until app_rdy is sampled high; then deassert app_en, increment rd_issued, and go to IDLE.
REQ-023 Minimum latency:
  - Write: grant at cycle N, app_wdf_wren at N+1, app_en at N+2 (rdy signals high); back in IDLE at N+3.
  - Read: grant at N, app_en at N+1, back in IDLE at N+2.
REQ-024 At most one pop strobe shall be high in any cycle, and pops shall occur only in IDLE.
REQ-025 Missing data: has_wr_adx high with has_wr_data low shall not grant a write, and pops neither FIFO.
REQ-026 The block shall ignore app_rdy and app_wdf_rdy outside the states that wait on them.
REQ-027 Counters shall wrap from 16'hFFFF to 0.

Reset
REQ-028 On reset assertion, including mid-transaction, the block shall immediately:
  - go to IDLE;
  - set app_en, app_wdf_wren, app_wdf_end, busy and all pop strobes to 0;
  - set app_cmd, app_addr and app_wdf_data to 0;
  - clear starve_cnt, wr_issued and rd_issued to 0.
REQ-029 A transaction in flight at reset is abandoned and is not re-issued.
REQ-030 The first grant may occur in the first clock edge after reset deasserts.

Verification
REQ-031 Single write, adx=27'h0000123, data=128'hA5..A5, both rdy signals high -> one pop pulse on each FIFO; app_wdf_wren at N+1; app_en with cmd 000 and addr 0x123 at N+2; wr_issued=1.
REQ-032 Single read, adx=27'h0000040, app_rdy held low for 5 cycles -> app_en and address held stable for 6 cycles; rd_issued=1; get_rd_adx pulses exactly once.
REQ-033 Continuous writes with a read pending, STARVE_LIMIT=8 -> exactly 8 writes are granted, then the read, then writes resume; starve_cnt returns to 0.
REQ-034 app_wdf_rdy low for 3 cycles during WR_DATA -> wren and data stable throughout; no app_en until app_wdf_rdy is sampled high.
REQ-035 has_wr_adx=1, has_wr_data=0 with a read eligible -> the read is granted and no write pop occurs.
REQ-036 Reset asserted in WR_CMD -> all outputs return to their reset values asynchronously; no further pop occurs; counters read 0.
